// File: rtl/lsu_dc_arb_pkg.sv
// Shared types and sizing helpers for the LSU D$ port arbiter.
package lsu_dc_arb_pkg;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_LOAD  = 2'd1,
        SEL_STORE = 2'd2,
        SEL_FILL  = 2'd3
    } dc_port_sel_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ST_RESOLVE = 2'd1,
        FILL       = 2'd2
    } lsu_dc_arb_state_t;

    function automatic int fill_beats(input int data_width, input int line_width);
        return (1 << line_width) / (data_width / 8);
    endfunction

    // A single-beat line still needs a 1-bit beat bus.
    function automatic int beat_w(input int data_width, input int line_width);
        int fb;
        fb = fill_beats(data_width, line_width);
        return (fb > 1) ? $clog2(fb) : 1;
    endfunction

endpackage

// File: rtl/lsu_dc_arb_if.sv
// Request/grant bundle between the fill, store and load requesters and the D$ port arbiter.
interface lsu_dc_arb_if
    import lsu_dc_arb_pkg::*;
#(
    parameter int BEAT_W = 3
);
    logic              i_flush;
    logic              i_fill_en;
    logic              o_fill_ack;
    logic [BEAT_W-1:0] o_fill_beat;
    logic              o_fill_done;
    logic              i_st_req;
    logic              i_st_dc_hit;
    logic              i_mshq_full;
    logic              o_st_write;
    logic              o_st_mshq_alloc;
    logic              o_st_done;
    logic              o_st_stall;
    logic              i_ld_req;
    logic              o_ld_gnt;
    logic              o_dc_rd_en;
    logic              o_dc_wr_en;
    dc_port_sel_t      o_dc_sel;

    modport master (
        output i_flush, i_fill_en, i_st_req, i_st_dc_hit, i_mshq_full, i_ld_req,
        input  o_fill_ack, o_fill_beat, o_fill_done, o_st_write, o_st_mshq_alloc,
               o_st_done, o_st_stall, o_ld_gnt, o_dc_rd_en, o_dc_wr_en, o_dc_sel
    );

    modport slave (
        input  i_flush, i_fill_en, i_st_req, i_st_dc_hit, i_mshq_full, i_ld_req,
        output o_fill_ack, o_fill_beat, o_fill_done, o_st_write, o_st_mshq_alloc,
               o_st_done, o_st_stall, o_ld_gnt, o_dc_rd_en, o_dc_wr_en, o_dc_sel
    );
endinterface

// File: rtl/lsu_dc_arb_starve.sv
// Saturating count of consecutive cycles a pending load has been denied the D$ port.
module lsu_dc_arb_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic ld_req,
    input  logic ld_gnt,
    input  logic flush,
    output logic starved
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (ld_gnt || !ld_req || flush) begin
            cnt <= '0;
        end else if (!starved) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starved = (cnt == CW'(STARVE_LIMIT));

endmodule

// File: rtl/lsu_dc_arb.sv
// Sequences the single D$ port between MSHQ fills, retiring stores and load lookups.
module lsu_dc_arb
    import lsu_dc_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DC_LINE_WIDTH = 5,
    parameter int STARVE_LIMIT  = 4
) (
    input logic         clk,
    input logic         n_rst,
    lsu_dc_arb_if.slave bus
);
    localparam int FILL_BEATS = fill_beats(DATA_WIDTH, DC_LINE_WIDTH);
    localparam int BEAT_W     = beat_w(DATA_WIDTH, DC_LINE_WIDTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FILL_BEATS - 1);

    lsu_dc_arb_state_t state, state_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt, beat_out;
    logic              starved;
    logic              fill_ack, fill_done, st_write, st_alloc, st_done, st_stall;
    logic              ld_gnt, rd_en, wr_en;
    dc_port_sel_t      sel;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        beat_out  = '0;
        fill_ack  = 1'b0;
        fill_done = 1'b0;
        st_write  = 1'b0;
        st_alloc  = 1'b0;
        st_done   = 1'b0;
        st_stall  = 1'b0;
        ld_gnt    = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        sel       = SEL_NONE;
        case (state)
            IDLE: begin
                // Fills are non-speculative, so flush never holds them off.
                if (bus.i_fill_en) begin
                    wr_en    = 1'b1;
                    sel      = SEL_FILL;
                    fill_ack = 1'b1;
                    if (FILL_BEATS == 1) begin
                        fill_done = 1'b1;
                    end else begin
                        state_nxt = FILL;
                        beat_nxt  = BEAT_W'(1);
                    end
                end else if (!bus.i_flush) begin
                    if (bus.i_ld_req && (starved || !bus.i_st_req)) begin
                        ld_gnt = 1'b1;
                        rd_en  = 1'b1;
                        sel    = SEL_LOAD;
                    end else if (bus.i_st_req) begin
                        rd_en     = 1'b1;
                        sel       = SEL_STORE;
                        state_nxt = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                state_nxt = IDLE;
                if (!bus.i_flush) begin
                    if (bus.i_st_dc_hit) begin
                        wr_en    = 1'b1;
                        sel      = SEL_STORE;
                        st_write = 1'b1;
                        st_done  = 1'b1;
                    end else if (!bus.i_mshq_full) begin
                        st_alloc = 1'b1;
                        st_done  = 1'b1;
                    end else begin
                        st_stall = 1'b1;
                    end
                end
            end
            FILL: begin
                beat_out = beat;
                if (bus.i_fill_en) begin
                    wr_en    = 1'b1;
                    sel      = SEL_FILL;
                    fill_ack = 1'b1;
                    if (beat == LAST_BEAT) begin
                        fill_done = 1'b1;
                        beat_nxt  = '0;
                        state_nxt = IDLE;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    lsu_dc_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk    (clk),
        .n_rst  (n_rst),
        .ld_req (bus.i_ld_req),
        .ld_gnt (ld_gnt),
        .flush  (bus.i_flush),
        .starved(starved)
    );

    // Outputs are combinational, so they are forced quiet while reset is held.
    assign bus.o_fill_ack      = n_rst & fill_ack;
    assign bus.o_fill_beat     = n_rst ? beat_out : '0;
    assign bus.o_fill_done     = n_rst & fill_done;
    assign bus.o_st_write      = n_rst & st_write;
    assign bus.o_st_mshq_alloc = n_rst & st_alloc;
    assign bus.o_st_done       = n_rst & st_done;
    assign bus.o_st_stall      = n_rst & st_stall;
    assign bus.o_ld_gnt        = n_rst & ld_gnt;
    assign bus.o_dc_rd_en      = n_rst & rd_en;
    assign bus.o_dc_wr_en      = n_rst & wr_en;
    assign bus.o_dc_sel        = n_rst ? sel : SEL_NONE;

endmodule

// File: doc/lsu_dc_arb.md
Name: lsu_dc_arb

Overview:
- Arbitrates and sequences the single D$ read/write port between three requesters:
  - MSHQ line fills (multi-beat)
  - retiring stores from the store queue (lookup then write/allocate)
  - load lookups from LSU_MEM
- Sits between the LSU pipeline, the SQ retire path, the MSHQ and the D$ arrays.
- Drives the D$ input mux select and the read/write enables.

Parameters:
- DATA_WIDTH, 32, data word width in bits.
- DC_LINE_WIDTH, 5, log2 of D$ line size in bytes.
- STARVE_LIMIT, 4, consecutive denied cycles after which a load outranks a store.
- Derived: FILL_BEATS = 2^DC_LINE_WIDTH / (DATA_WIDTH/8) (8 at defaults); BEAT_W = $clog2(FILL_BEATS).

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- i_flush  in  1  pipeline flush
- i_fill_en  in  1  MSHQ has a fill beat valid
- o_fill_ack  out  1  current fill beat written this cycle
- o_fill_beat  out  BEAT_W  index of beat being written
- o_fill_done  out  1  last beat written
- i_st_req  in  1  SQ retiring store pending (held until o_st_done)
- i_st_dc_hit  in  1  D$ hit result of store lookup (valid in ST_RESOLVE)
- i_mshq_full  in  1  MSHQ cannot accept allocation
- o_st_write  out  1  write store data to D$
- o_st_mshq_alloc  out  1  allocate/merge missing store in MSHQ
- o_st_done  out  1  store completed; SQ/ROB may retire
- o_st_stall  out  1  store missed with MSHQ full; ROB retire stalled
- i_ld_req  in  1  load requests D$ lookup
- o_ld_gnt  out  1  load owns port this cycle
- o_dc_rd_en  out  1  D$ tag/data read
- o_dc_wr_en  out  1  D$ write
- o_dc_sel  out  2  port owner: 0 none, 1 load, 2 store, 3 fill

Behaviour:
- Reset: state IDLE, beat counter 0, starve counter 0. All outputs are 0 while n_rst is low.
- Outputs are combinational from state, counters and inputs. Only state and counters are registered.
- IDLE priority:
  - Fill is always highest.
  - If starve count == STARVE_LIMIT, load outranks store. Otherwise store outranks load.
- IDLE, fill grant (i_fill_en):
  - Same cycle: o_dc_wr_en=1, sel=3, o_fill_ack=1, beat=0.
  - Next state FILL with counter 1.
  - If FILL_BEATS==1: o_fill_done and remain IDLE.
- IDLE, store grant: o_dc_rd_en=1, sel=2; next state ST_RESOLVE.
- IDLE, load grant: o_ld_gnt=1, o_dc_rd_en=1, sel=1; remain IDLE. Single-cycle, zero latency.
- FILL:
  - When i_fill_en: write beat counter, ack, increment.
  - When i_fill_en is low: bubble (no write, no ack), counter holds.
  - On beat FILL_BEATS-1: o_fill_done=1, counter to 0, return to IDLE.
  - Stores and loads are blocked throughout.
- ST_RESOLVE, exactly one of:
  - Hit: o_dc_wr_en=1, sel=2, o_st_write=1, o_st_done=1.
  - Miss with MSHQ not full: o_st_mshq_alloc=1, o_st_done=1.
  - Miss with MSHQ full: o_st_stall=1, no done.
  - Next state is IDLE in all cases. A stalled store re-arbitrates and re-looks-up while i_st_req is held.
- Starve counter:
  - Resets to 0 when o_ld_gnt or ~i_ld_req.
  - Otherwise increments and saturates at STARVE_LIMIT.
  - Counts cycles lost to fills and ST_RESOLVE as well as to store grants.
- i_flush:
  - In ST_RESOLVE: suppresses write, alloc, done and stall; returns to IDLE.
  - In IDLE: suppresses new store and load grants. Fill grants are unaffected.
  - FILL is never aborted; fills are non-speculative.
  - Starve counter clears on flush.
- Simultaneous fill, store and load in IDLE: fill wins; the store waits in i_st_req.
- Reset asserted mid-FILL or mid-ST_RESOLVE: immediate return to IDLE, counters cleared. MSHQ and SQ must re-present requests.
- At most one of o_st_write / o_st_mshq_alloc / o_st_stall is asserted per cycle.
- o_dc_rd_en and o_dc_wr_en are never both asserted in the same cycle.

Decomposition:
- Shared package:
  - dc_port_sel_t enum: NONE, LOAD, STORE, FILL.
  - lsu_dc_arb_state_t enum: IDLE, ST_RESOLVE, FILL.
- One sub-module: lsu_dc_arb_starve, the saturating starvation counter with its compare output.

Test Plan:
- Load alone: i_ld_req=1 for 3 cycles -> o_ld_gnt=1 each cycle, sel=1, starve count stays 0.
- Store hit: i_st_req=1, i_st_dc_hit=1 at cycle 2 -> cycle1 rd_en/sel=2; cycle2 wr_en, o_st_write, o_st_done.
- Store miss with MSHQ full, then freed:
  - Cycle2 i_mshq_full=1 -> o_st_stall=1, no done.
  - Retry lookup at cycle3; i_mshq_full=0 at cycle4 -> o_st_mshq_alloc and o_st_done at cycle4.
- Fill with bubble: i_fill_en high 8 cycles with low at beat 3 -> acks beats 0-7 over 9 cycles, o_fill_done on beat 7; concurrent i_ld_req never granted during the burst.
- Starvation: i_st_req and i_ld_req continuously high, no misses -> load granted in the first IDLE cycle where starve==4; counter then returns to 0.
- Flush in ST_RESOLVE with i_st_dc_hit=1 -> no wr_en, no done, state IDLE next cycle; async n_rst asserted mid-fill at beat 5 -> outputs 0 immediately, beat counter 0 after release.
